// File: rtl/regs_file_scoreboard.sv
// ============================================================================
// Module   : regs_file_scoreboard
// Brief    : Architectural register file: two combinational read ports, a
//            write-back port, and a per-register pending-write scoreboard
//            that drives the decode stall. Macro REGS_BYPASS_EN enables
//            write-first bypass from write-back on both the data and stall
//            paths.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

module regs_file_scoreboard #(
  parameter int DATA_W = `DATAWIDTH,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              cancel_en,
  input  logic [ADDR_W-1:0] cancel_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              stall,
  output logic              issue_fire
);

  localparam int              NREG      = 2**ADDR_W;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];

  logic w_wb_hit1, w_wb_hit2;
  logic w_haz1, w_haz2, w_sat;

  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
`ifdef REGS_BYPASS_EN
    if (wb_en && (wb_rd == rs1_addr)) rs1_data = wb_data;
    if (wb_en && (wb_rd == rs2_addr)) rs2_data = wb_data;
`endif
    if (rs1_addr == '0) rs1_data = '0;
    if (rs2_addr == '0) rs2_data = '0;
  end

  // The in-flight write-back retires one pending writer for the source check.
`ifdef REGS_BYPASS_EN
  assign w_wb_hit1 = wb_en & (wb_rd == rs1_addr);
  assign w_wb_hit2 = wb_en & (wb_rd == rs2_addr);
`else
  assign w_wb_hit1 = 1'b0;
  assign w_wb_hit2 = 1'b0;
`endif

  assign w_haz1 = rs1_used & (rs1_addr != '0) &
                  (cnt_q[rs1_addr] != {{(CNT_W-1){1'b0}}, w_wb_hit1});
  assign w_haz2 = rs2_used & (rs2_addr != '0) &
                  (cnt_q[rs2_addr] != {{(CNT_W-1){1'b0}}, w_wb_hit2});

  assign w_sat = issue_wr & (issue_rd != '0) & (cnt_q[issue_rd] == C_CNT_MAX) &
                 ~(wb_en & (wb_rd == issue_rd)) &
                 ~(cancel_en & (cancel_rd == issue_rd));

  assign stall      = issue_valid & (w_haz1 | w_haz2 | w_sat);
  assign issue_fire = issue_valid & ~stall;

  generate
    for (genvar r = 0; r < NREG; r++) begin : g_cnt
      logic             w_inc, w_dwb, w_dcan;
      logic [CNT_W:0]   w_up, w_dec;

      assign w_inc  = (r != 0) & issue_fire & issue_wr & (issue_rd == ADDR_W'(r));
      assign w_dwb  = wb_en & (wb_rd == ADDR_W'(r));
      assign w_dcan = cancel_en & (cancel_rd == ADDR_W'(r));

      assign w_up  = {1'b0, cnt_q[r]} + {{CNT_W{1'b0}}, w_inc};
      assign w_dec = {{CNT_W{1'b0}}, w_dwb} + {{CNT_W{1'b0}}, w_dcan};

      // Excess decrements clamp at zero instead of wrapping.
      assign cnt_d[r] = (w_up > w_dec) ? CNT_W'(w_up - w_dec) : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (wb_en && (wb_rd != '0)) regs_q[wb_rd] <= wb_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regs_file_scoreboard.sv
// ============================================================================
// Module   : tb_regs_file_scoreboard
// Brief    : Directed plus random bench for regs_file_scoreboard against an
//            array-based model of the register file and pending counts.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regs_file_scoreboard;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CW   = 2;
  localparam int NR   = 32;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst, wb_en, cancel_en, rs1_used, rs2_used;
  logic          issue_valid, issue_wr, stall, issue_fire;
  logic [AW-1:0] wb_rd, cancel_rd, rs1_addr, rs2_addr, issue_rd;
  logic [DW-1:0] wb_data, rs1_data, rs2_data;

  always #5 clk = ~clk;

  regs_file_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .cancel_en(cancel_en), .cancel_rd(cancel_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall(stall), .issue_fire(issue_fire)
  );

  logic [DW-1:0] m_regs [NR];
  int            m_cnt  [NR];
  int            n_total = 0;
  int            n_pass  = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGS_BYPASS_EN
    if (wb_en && wb_rd == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic bit exp_haz(input logic used, input logic [AW-1:0] a);
    int pend = m_cnt[a];
`ifdef REGS_BYPASS_EN
    if (wb_en && wb_rd == a) pend = pend - 1;
`endif
    return used && (a != 0) && (pend != 0);
  endfunction

  task automatic idle();
    rst = 0; wb_en = 0; wb_rd = 0; wb_data = 0; cancel_en = 0; cancel_rd = 0;
    rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
    issue_valid = 0; issue_wr = 0; issue_rd = 0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic cyc(input bit chk);
    bit e_stall, e_fire, sat;
    int nc;
    #4;
    sat = issue_wr && issue_rd != 0 && m_cnt[issue_rd] == CMAX &&
          !(wb_en && wb_rd == issue_rd) && !(cancel_en && cancel_rd == issue_rd);
    e_stall = issue_valid && (exp_haz(rs1_used, rs1_addr) || exp_haz(rs2_used, rs2_addr) || sat);
    e_fire  = issue_valid && !e_stall;
    if (chk) begin
      check("rs1_data", rs1_data, exp_rd(rs1_addr));
      check("rs2_data", rs2_data, exp_rd(rs2_addr));
      check("stall", DW'(stall), DW'(e_stall));
      check("issue_fire", DW'(issue_fire), DW'(e_fire));
    end
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_regs[r] = '0;
        m_cnt[r]  = 0;
      end
    end else begin
      if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
      for (int r = 1; r < NR; r++) begin
        nc = m_cnt[r];
        if (e_fire && issue_wr && issue_rd == AW'(r)) nc = nc + 1;
        if (wb_en && wb_rd == AW'(r)) nc = nc - 1;
        if (cancel_en && cancel_rd == AW'(r)) nc = nc - 1;
        m_cnt[r] = (nc < 0) ? 0 : nc;
      end
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    cyc(0);
    cyc(0);
    rst = 0;

    // All indices read zero after reset, no stall.
    for (int a = 0; a < NR; a++) begin
      rs1_addr = AW'(a); rs2_addr = AW'(NR - 1 - a);
      rs1_used = 1; rs2_used = 1; issue_valid = 1;
      cyc(1);
    end
    idle();

    // x0 ignores writes.
    wb_en = 1; wb_rd = 0; wb_data = 32'hDEADBEEF; rs1_addr = 0;
    cyc(1);
    idle();
    cyc(1);
    check("x0_after_write", rs1_data, 32'h0);

    // Write x5 with same-cycle read, then read next cycle.
    wb_en = 1; wb_rd = 5; wb_data = 32'h12345678; rs1_addr = 5;
    cyc(1);
    wb_en = 0;
    cyc(1);
    check("x5_landed", rs1_data, 32'h12345678);

    // RAW hazard on x7 resolved by write-back.
    idle();
    issue_valid = 1; issue_wr = 1; issue_rd = 7;
    cyc(1);
    issue_wr = 0; issue_rd = 0; rs2_addr = 7; rs2_used = 1;
    cyc(1);
    cyc(1);
    wb_en = 1; wb_rd = 7; wb_data = 32'hA5A5_0007;
    cyc(1);
    wb_en = 0;
    cyc(1);
    check("x7_stall_cleared", DW'(stall), 32'h0);

    // Saturate x3 and issue under a simultaneous write-back.
    idle();
    issue_valid = 1; issue_wr = 1; issue_rd = 3;
    cyc(1); cyc(1); cyc(1);
    cyc(1);
    wb_en = 1; wb_rd = 3; wb_data = 32'h3333_0001;
    cyc(1);
    wb_en = 0;
    cyc(1);

    // Cancel releases x9; wb + cancel together drop x3 by two.
    idle();
    issue_valid = 1; issue_wr = 1; issue_rd = 9;
    cyc(1);
    idle();
    cancel_en = 1; cancel_rd = 9;
    cyc(1);
    idle();
    issue_valid = 1; rs1_addr = 9; rs1_used = 1;
    cyc(1);
    idle();
    wb_en = 1; wb_rd = 3; wb_data = 32'h3333_0002;
    cyc(1);
    cancel_en = 1; cancel_rd = 3; wb_data = 32'h3333_0003;
    cyc(1);
    idle();
    issue_valid = 1; rs1_addr = 3; rs1_used = 1; rs2_addr = 3; rs2_used = 1;
    cyc(1);
    check("x3_drained_nostall", DW'(stall), 32'h0);

    // Reset drops pending x4 writers and clears registers.
    idle();
    issue_valid = 1; issue_wr = 1; issue_rd = 4;
    cyc(1); cyc(1);
    idle();
    issue_valid = 1; rs1_addr = 4; rs1_used = 1; rs2_addr = 5; rs2_used = 1;
    rst = 1;
    cyc(1);
    rst = 0;
    cyc(1);
    check("post_reset_x5", rs2_data, 32'h0);

    // Random traffic on a small index range to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      rst         = ($urandom_range(0, 149) == 0);
      wb_en       = ($urandom_range(0, 2) == 0);
      wb_rd       = AW'($urandom_range(0, 7));
      wb_data     = $urandom;
      cancel_en   = ($urandom_range(0, 9) == 0);
      cancel_rd   = AW'($urandom_range(0, 7));
      rs1_addr    = AW'($urandom_range(0, 7));
      rs2_addr    = AW'($urandom_range(0, 7));
      rs1_used    = ($urandom_range(0, 1) == 0);
      rs2_used    = ($urandom_range(0, 1) == 0);
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_wr    = ($urandom_range(0, 3) != 0);
      issue_rd    = AW'($urandom_range(0, 7));
      cyc(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
